blur_frame_controller: RTL and testbench
========================================

Name: blur_frame_controller

Overview:
Frame-level sequencer for the 1x1/3x3/5x5 RGB444 blurring filter on the 320x240 video stream. It tracks pixel position from the streaming handshake. It applies kernel-size changes only at start of frame, so a frame is never blurred with mixed kernels. It produces a border mask, aligned to the filter's output pipeline, that marks pixels whose window is incomplete. It also checks frame framing and flags short, long or restarted frames.

Parameters:
IMG_WIDTH, 320, active pixels per line
IMG_HEIGHT, 240, active lines per frame
PIPE_LATENCY, 5, cycles from an accepted filter input beat to the matching filter output beat (delay applied to border_mask_out)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
freq_flag_req  in  3  requested kernel size (0=1x1, 1=3x3, 2 or 3=5x5), asynchronous to frames (switches)
valid_in  in  1  upstream beat valid
ready_in  in  1  downstream ready; a beat is accepted when valid_in && ready_in
startofpacket_in  in  1  SOP qualifier of the accepted beat
endofpacket_in  in  1  EOP qualifier of the accepted beat
freq_flag  out  3  kernel size driven to the filter; stable for a whole frame
x_count  out  9  column of the next beat to be accepted (0..IMG_WIDTH-1)
y_count  out  8  line of the next beat to be accepted (0..IMG_HEIGHT-1)
border_mask_out  out  1  high when the filter output beat on this cycle lies in the invalid border
frame_active  out  1  high between an accepted SOP and the end of that frame
change_pending  out  1  freq_flag_req differs from freq_flag and is waiting for the next SOP
frame_done  out  1  one-cycle pulse: the frame closed with the correct pixel count
err_short  out  1  one-cycle pulse: EOP arrived before IMG_WIDTH*IMG_HEIGHT beats
err_long  out  1  one-cycle pulse: beat IMG_WIDTH*IMG_HEIGHT accepted with no EOP on the last beat
err_restart  out  1  one-cycle pulse: SOP accepted while frame_active

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE.
  - freq_flag=0, x_count=0, y_count=0, frame_active=0.
  - All pulse outputs 0, change_pending=0.
  - Border delay line cleared, so border_mask_out=0.
- Reset mid-frame abandons the frame silently; no error pulse is issued.
- Beats that are not accepted (valid_in=0 or ready_in=0) change no counters or state.
- The border delay line shifts every cycle that ready_in=1, the same stall behaviour as the filter's buffer.
- States:
  - IDLE: waiting for SOP. Non-SOP accepted beats are ignored, with no error and no counting.
  - ACTIVE: counting beats.
- Accepted SOP, from any state:
  - freq_flag <= (freq_flag_req==3 ? 2 : freq_flag_req).
  - The SOP beat is pixel (0,0); after it, x_count=1, y_count=0.
  - state=ACTIVE, frame_active=1.
  - If already ACTIVE, err_restart pulses the following cycle and the new frame starts normally.
- Counting in ACTIVE:
  - x_count increments per accepted beat.
  - At IMG_WIDTH-1, x_count wraps to 0 and y_count increments.
- Last beat (x=IMG_WIDTH-1, y=IMG_HEIGHT-1) accepted:
  - With EOP: frame_done pulses next cycle, state=IDLE, counters return to 0.
  - Without EOP: err_long pulses, state=IDLE, counters return to 0.
- EOP accepted on any other beat: err_short pulses, state=IDLE, counters return to 0.
- SOP and EOP on the same beat: treated as SOP then immediate short frame, so err_short pulses (plus err_restart if a frame was active). State returns to IDLE.
- Kernel radius R: 0 for freq_flag 0, 1 for freq_flag 1, 2 for freq_flag 2 or 3.
- Border flag for an accepted beat at (x,y): b = (x<R) || (x>=IMG_WIDTH-R) || (y<R) || (y>=IMG_HEIGHT-R), using the freq_flag in force for that beat.
  - With R=0, b is always 0.
  - For the SOP beat, b uses the newly latched value.
- b enters the delay line, so border_mask_out equals b exactly PIPE_LATENCY ready_in=1 cycles after the beat was accepted.
  - Cycles with no accepted beat insert 0.
- change_pending = frame_active && (mapped freq_flag_req != freq_flag), registered with 1-cycle latency.
  - It clears on the cycle after the SOP that applies the change.
- freq_flag never changes except on an accepted SOP.
- The three error pulses and frame_done are mutually exclusive within one frame close, except err_restart together with err_short on an SOP+EOP beat.

Test Plan:
1. Reset, then a full 320x240 frame with freq_flag_req=1 -> freq_flag=1 after the SOP, frame_done pulses once, no errors, x/y return to 0.
2. freq_flag_req goes 1->2 at pixel (100,50) -> change_pending=1 until the next SOP, freq_flag stays 1 for the rest of the frame, becomes 2 after the next SOP.
3. freq_flag=2, run pixels with ready_in held 1 -> border_mask_out=1 for pixels (0..1,y), (318..319,y) and lines 0,1,238,239. Each appears 5 cycles after acceptance; the interior is 0.
4. Random valid_in/ready_in stalls over a full frame -> pixel count is still exactly 76800, frame_done pulses, and the mask stays aligned to accepted beats.
5. EOP at beat 1000 -> err_short pulses, state returns to IDLE. Next frame with no EOP on beat 76799 -> err_long pulses.
6. SOP at pixel (10,3) mid-frame -> err_restart pulses, counters restart at (1,0). Then reset_n=0 mid-frame -> all outputs at reset values and no error pulses.

Source files
------------

// File: rtl/blur_frame_controller.sv
// rtl/blur_frame_controller.sv - frame sequencer for the RGB444 blur filter: position tracking, kernel latch, border mask, framing checks
module blur_frame_controller #(
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int PIPE_LATENCY = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] freq_flag_req,
  input  logic       valid_in,
  input  logic       ready_in,
  input  logic       startofpacket_in,
  input  logic       endofpacket_in,
  output logic [2:0] freq_flag,
  output logic [8:0] x_count,
  output logic [7:0] y_count,
  output logic       border_mask_out,
  output logic       frame_active,
  output logic       change_pending,
  output logic       frame_done,
  output logic       err_short,
  output logic       err_long,
  output logic       err_restart
);

  localparam logic [8:0] X_LAST = 9'(IMG_WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q;
  logic [2:0]  freq_flag_q;
  logic [8:0]  x_count_q;
  logic [7:0]  y_count_q;
  logic        frame_active_q;
  logic        change_pending_q;
  logic        frame_done_q;
  logic        err_short_q;
  logic        err_long_q;
  logic        err_restart_q;
  logic [PIPE_LATENCY-1:0] mask_q;

  logic        accept;
  logic [2:0]  req_map;
  logic [2:0]  sel_flag;
  logic [9:0]  bx;
  logic [9:0]  by;
  logic [9:0]  br;
  logic        border_bit;
  logic        mask_d;

  // Kernel radius: 1x1 -> 0, 3x3 -> 1, 5x5 -> 2
  function automatic logic [1:0] radius(input logic [2:0] flag);
    case (flag)
      3'd0:    radius = 2'd0;
      3'd1:    radius = 2'd1;
      default: radius = 2'd2;
    endcase
  endfunction

  // Beat acceptance, request mapping and border flag for the beat being accepted;
  // an SOP beat is pixel (0,0) and already uses the kernel it latches
  always_comb begin
    accept     = valid_in && ready_in;
    req_map    = (freq_flag_req == 3'd3) ? 3'd2 : freq_flag_req;
    sel_flag   = startofpacket_in ? req_map : freq_flag_q;
    bx         = startofpacket_in ? 10'd0 : {1'b0, x_count_q};
    by         = startofpacket_in ? 10'd0 : {2'b00, y_count_q};
    br         = {8'd0, radius(sel_flag)};
    border_bit = (bx < br) || ((bx + br) >= 10'(IMG_WIDTH)) ||
                 (by < br) || ((by + br) >= 10'(IMG_HEIGHT));
    mask_d     = accept && (startofpacket_in || (state_q == ACTIVE)) && border_bit;
  end

  // Frame FSM: position counters, kernel latch, pending flag and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      freq_flag_q      <= 3'd0;
      x_count_q        <= 9'd0;
      y_count_q        <= 8'd0;
      frame_active_q   <= 1'b0;
      change_pending_q <= 1'b0;
      frame_done_q     <= 1'b0;
      err_short_q      <= 1'b0;
      err_long_q       <= 1'b0;
      err_restart_q    <= 1'b0;
    end else begin
      frame_done_q     <= 1'b0;
      err_short_q      <= 1'b0;
      err_long_q       <= 1'b0;
      err_restart_q    <= 1'b0;
      change_pending_q <= frame_active_q && (req_map != freq_flag_q);
      if (accept) begin
        if (startofpacket_in) begin
          freq_flag_q      <= req_map;
          err_restart_q    <= (state_q == ACTIVE);
          change_pending_q <= 1'b0;
          if (endofpacket_in) begin
            err_short_q    <= 1'b1;
            state_q        <= IDLE;
            frame_active_q <= 1'b0;
            x_count_q      <= 9'd0;
            y_count_q      <= 8'd0;
          end else begin
            state_q        <= ACTIVE;
            frame_active_q <= 1'b1;
            x_count_q      <= 9'd1;
            y_count_q      <= 8'd0;
          end
        end else if (state_q == ACTIVE) begin
          if ((x_count_q == X_LAST) && (y_count_q == Y_LAST)) begin
            frame_done_q     <= endofpacket_in;
            err_long_q       <= !endofpacket_in;
            state_q          <= IDLE;
            frame_active_q   <= 1'b0;
            change_pending_q <= 1'b0;
            x_count_q        <= 9'd0;
            y_count_q        <= 8'd0;
          end else if (endofpacket_in) begin
            err_short_q      <= 1'b1;
            state_q          <= IDLE;
            frame_active_q   <= 1'b0;
            change_pending_q <= 1'b0;
            x_count_q        <= 9'd0;
            y_count_q        <= 8'd0;
          end else if (x_count_q == X_LAST) begin
            x_count_q <= 9'd0;
            y_count_q <= y_count_q + 8'd1;
          end else begin
            x_count_q <= x_count_q + 9'd1;
          end
        end
      end
    end
  end

  // Border delay line, stalled with the filter pipeline whenever ready_in is low
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (ready_in) begin
      mask_q <= {mask_q[PIPE_LATENCY-2:0], mask_d};
    end
  end

  assign freq_flag       = freq_flag_q;
  assign x_count         = x_count_q;
  assign y_count         = y_count_q;
  assign border_mask_out = mask_q[PIPE_LATENCY-1];
  assign frame_active    = frame_active_q;
  assign change_pending  = change_pending_q;
  assign frame_done      = frame_done_q;
  assign err_short       = err_short_q;
  assign err_long        = err_long_q;
  assign err_restart     = err_restart_q;

endmodule

// File: tb/tb_blur_frame_controller.sv
// tb/tb_blur_frame_controller.sv - randomized self-checking bench for blur_frame_controller against a frame-level model
module tb_blur_frame_controller;

  localparam int W   = 12;
  localparam int H   = 10;
  localparam int LAT = 5;
  localparam int N   = W * H;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] freq_flag_req;
  logic       valid_in;
  logic       ready_in;
  logic       startofpacket_in;
  logic       endofpacket_in;
  logic [2:0] freq_flag;
  logic [8:0] x_count;
  logic [7:0] y_count;
  logic       border_mask_out;
  logic       frame_active;
  logic       change_pending;
  logic       frame_done;
  logic       err_short;
  logic       err_long;
  logic       err_restart;

  blur_frame_controller #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PIPE_LATENCY(LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .freq_flag_req   (freq_flag_req),
    .valid_in        (valid_in),
    .ready_in        (ready_in),
    .startofpacket_in(startofpacket_in),
    .endofpacket_in  (endofpacket_in),
    .freq_flag       (freq_flag),
    .x_count         (x_count),
    .y_count         (y_count),
    .border_mask_out (border_mask_out),
    .frame_active    (frame_active),
    .change_pending  (change_pending),
    .frame_done      (frame_done),
    .err_short       (err_short),
    .err_long        (err_long),
    .err_restart     (err_restart)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: frame in progress, index of next pixel in raster order, latched kernel
  bit m_active;
  int m_pix;
  int m_flag;
  bit m_pend, m_done, m_short, m_long, m_restart;
  bit mq[$];
  int n_done, n_short, n_long, n_restart;
  logic [2:0] cur_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int map_req(input logic [2:0] r);
    return (r == 3'd3) ? 2 : int'(r);
  endfunction

  function automatic bit border_of(input int pix, input int flag);
    int x, y, r;
    x = pix % W;
    y = pix / W;
    r = (flag == 0) ? 0 : (flag == 1) ? 1 : 2;
    return (x < r) || (x >= W - r) || (y < r) || (y >= H - r);
  endfunction

  task automatic model_reset();
    m_active = 0; m_pix = 0; m_flag = 0;
    m_pend = 0; m_done = 0; m_short = 0; m_long = 0; m_restart = 0;
    mq.delete();
    for (int i = 0; i < LAT; i++) mq.push_back(1'b0);
  endtask

  task automatic step(input bit rn, input bit v, input bit r, input bit s, input bit e,
                      input logic [2:0] req);
    bit b;
    reset_n = rn; valid_in = v; ready_in = r;
    startofpacket_in = s; endofpacket_in = e; freq_flag_req = req;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      m_done = 0; m_short = 0; m_long = 0; m_restart = 0;
      b = 0;
      if (v && r) begin
        if (s) begin
          m_restart = m_active;
          m_flag = map_req(req);
          b = border_of(0, m_flag);
          if (e) begin m_short = 1; m_active = 0; m_pix = 0; end
          else begin m_active = 1; m_pix = 1; end
        end else if (m_active) begin
          b = border_of(m_pix, m_flag);
          m_pix++;
          if (m_pix == N) begin
            m_done = e; m_long = !e; m_active = 0; m_pix = 0;
          end else if (e) begin
            m_short = 1; m_active = 0; m_pix = 0;
          end
        end
      end
      m_pend = m_active && (map_req(req) != m_flag);
      if (r) begin
        mq.push_back(b);
        mq.delete(0);
      end
    end
    n_done += int'(m_done); n_short += int'(m_short);
    n_long += int'(m_long); n_restart += int'(m_restart);
    #1;
    chk("freq_flag", 32'(freq_flag), 32'(m_flag));
    chk("x_count", 32'(x_count), 32'(m_pix % W));
    chk("y_count", 32'(y_count), 32'(m_pix / W));
    chk("frame_active", 32'(frame_active), 32'(m_active));
    chk("change_pending", 32'(change_pending), 32'(m_pend));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("err_short", 32'(err_short), 32'(m_short));
    chk("err_long", 32'(err_long), 32'(m_long));
    chk("err_restart", 32'(err_restart), 32'(m_restart));
    chk("border_mask_out", 32'(border_mask_out), 32'(mq[0]));
  endtask

  // Deliver nbeats beats starting with SOP; EOP on beat eop_idx; kernel request
  // switches to chg_req when beat chg_idx is offered
  task automatic run_frame(input int nbeats, input int eop_idx, input bit stall,
                           input int chg_idx, input logic [2:0] chg_req);
    int idx = 0;
    int guard = 0;
    bit v, r;
    while (idx < nbeats && guard < 20 * nbeats + 100) begin
      v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (idx == chg_idx) cur_req = chg_req;
      step(1'b1, v, r, idx == 0, idx == eop_idx, cur_req);
      if (v && r) idx++;
      guard++;
    end
    chk("frame_beats_delivered", 32'(idx), 32'(nbeats));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, cur_req);
  endtask

  initial begin
    int d0, s0, l0, r0;
    n_done = 0; n_short = 0; n_long = 0; n_restart = 0;
    cur_req = 3'd1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_req);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, cur_req);

    // non-SOP beats in IDLE are ignored
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, i == 2, cur_req);

    // full frame, 3x3 kernel
    run_frame(N, N - 1, 1'b0, -1, 3'd0);
    idle_cycles(LAT + 2);
    chk("frames_done_after_first", 32'(n_done), 32'd1);

    // kernel request changes mid-frame, applied at next SOP
    run_frame(N, N - 1, 1'b0, 4 * W + 5, 3'd2);
    idle_cycles(3);
    run_frame(N, N - 1, 1'b0, -1, 3'd0);
    idle_cycles(LAT + 2);

    // random stalls and kernel 3 (maps to 5x5)
    cur_req = 3'd3;
    run_frame(N, N - 1, 1'b1, N / 2, 3'd0);
    idle_cycles(LAT + 2);

    // short frame then long frame
    d0 = n_done; s0 = n_short; l0 = n_long;
    cur_req = 3'd2;
    run_frame(50, 49, 1'b1, -1, 3'd0);
    idle_cycles(3);
    run_frame(N, -1, 1'b0, -1, 3'd0);
    idle_cycles(3);
    chk("short_count", 32'(n_short - s0), 32'd1);
    chk("long_count", 32'(n_long - l0), 32'd1);
    chk("done_unchanged", 32'(n_done - d0), 32'd0);

    // restart at pixel (10,3), then reset mid-frame
    r0 = n_restart;
    run_frame(3 * W + 10, -1, 1'b0, -1, 3'd0);
    run_frame(30, -1, 1'b0, 10, 3'd1);
    chk("restart_count", 32'(n_restart - r0), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, cur_req);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_req);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, cur_req);

    // SOP+EOP on one beat while idle and while active
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
    run_frame(7, -1, 1'b0, -1, 3'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1);
    idle_cycles(LAT + 1);

    // random framing soup with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 60) == 0) cur_req = 3'($urandom_range(0, 7));
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 79) == 0, $urandom_range(0, 99) == 0, cur_req);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
